bus_dma: RTL and testbench
==========================

BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 SHALL have parameter DMA_ADDRESS, default 8'h90, low-byte base of the 6-byte register window.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have slave ports din/address/w_en/r_en (input, 8/8/1/1) and dout (output, 8), matching the peripheral register bus.
REQ-005 SHALL have port m_address, output, 16, the master bus address.
REQ-006 SHALL have port m_dout, output, 8, the master write data.
REQ-007 SHALL have port m_din, input, 8, the master read data, valid one cycle after m_r_en.
REQ-008 SHALL have ports m_w_en and m_r_en, output, 1, the master strobes.
REQ-009 SHALL have port m_req, output, 1, the bus request; m_grant, input, 1, means the DMA owns the bus this cycle.
REQ-010 SHALL have ports done_flag (output, 1) and done_flag_clr (input, 1) for the interrupt flag.

Function
REQ-011 SHALL decode registers at DMA_ADDRESS+n: 0 SRC_LO, 1 SRC_HI, 2 DST_LO, 3 DST_HI, 4 LEN, 5 CTRL.
REQ-012 SHALL define CTRL bits as: bit0 START (write-1, reads 0), bit1 BUSY (RO), bit2 DONE (RO, mirrors done_flag), bit3 MODE, bit4 ABORT (write-1, reads 0).
REQ-013 SHALL register dout, valid the cycle after r_en with a matching address, and drive 8'h00 otherwise.
REQ-014 SHALL ignore writes to SRC/DST/LEN/MODE while BUSY=1; ABORT is the only write honoured while busy.
REQ-015 SHALL treat LEN=0 as 256 bytes.
REQ-016 SHALL implement FSM states IDLE, RD, CAP, WR, DONE.
REQ-017 SHALL, in IDLE, on a START write, load the working src/dst/count from the registers, set BUSY, and go to RD the next cycle.
REQ-018 SHALL, in RD with m_grant=1, drive m_r_en=1 with m_address=src and go to CAP; with m_grant=0, hold RD with no strobes.
REQ-019 SHALL, in CAP, latch m_din unconditionally (grant is ignored) and go to WR.
REQ-020 SHALL, in WR with m_grant=1, drive m_w_en=1, m_address=dst and m_dout=latch; then increment src and dst, decrement count, and go to DONE if count reaches 0, else RD.
REQ-021 SHALL, in WR with m_grant=0, hold WR with no strobes.
REQ-022 SHALL use a copy cost of exactly 3 cycles per byte under continuous grant; 256 bytes take 768 cycles from RD entry to DONE.
REQ-023 SHALL wrap src and dst modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-024 SHALL, in DONE, set done_flag, clear BUSY, and return to IDLE the next cycle.
REQ-025 SHALL hold m_req=1 in RD, CAP and WR, and 0 otherwise.
REQ-026 SHALL never assert m_r_en and m_w_en in the same cycle, and SHALL drive both to 0 outside RD/WR.
REQ-027 SHALL, on ABORT while busy, finish the current CAP→WR byte if in CAP, otherwise go to IDLE next cycle; done_flag SHALL NOT be set and BUSY SHALL clear.
REQ-028 SHALL give done_flag_clr priority over a simultaneous set, so a same-cycle clear wins.
REQ-029 SHALL ignore a START written while BUSY=1.
REQ-030 SHALL leave a START coinciding with the DONE cycle unaccepted; software SHALL reissue it.

Reset
REQ-031 SHALL, with rst=1 at posedge clk, force: state IDLE; all registers 0; done_flag=0; m_req/m_r_en/m_w_en=0; m_address=16'h0000; m_dout=8'h00; dout=8'h00.
REQ-032 SHALL, on rst mid-transfer, abort with no further strobes from the next cycle and leave done_flag=0.

Configuration
REQ-033 SHALL use macro BUS_DMA_FILL_EN to enable fill mode.
REQ-034 SHALL, when BUS_DMA_FILL_EN is defined and MODE=1, write SRC_LO as a constant byte to dst..dst+LEN-1, skip RD/CAP (1 cycle per byte under grant), and leave src unmodified.
REQ-035 SHALL, when BUS_DMA_FILL_EN is undefined, make MODE read 0, ignore writes to it, and omit the fill datapath.

Verification
REQ-036 SHALL cover: SRC=0x0100, DST=0x0200, LEN=4, START, grant=1 -> bytes copied, m_w_en pulses at cycles 3/6/9/12 after RD entry, done_flag=1, BUSY=0.
REQ-037 SHALL cover: SRC=0xFFFE, LEN=3 -> reads at 0xFFFE, 0xFFFF, 0x0000.
REQ-038 SHALL cover: grant toggling 0/1 every 2 cycles during LEN=8 -> data is correct, no strobe ever occurs while grant=0.
REQ-039 SHALL cover: LEN=0 -> exactly 256 writes; done_flag and done_flag_clr in the same cycle -> flag=0.
REQ-040 SHALL cover: ABORT in RD at byte 2 of 10, and rst in WR -> no further strobes, done_flag=0, BUSY=0.
REQ-041 SHALL cover: with BUS_DMA_FILL_EN, MODE=1, SRC_LO=0xA5, DST=0x0300, LEN=5 -> 5 writes of 0xA5 on consecutive cycles, m_r_en never asserted.

Source files
------------

// File: rtl/bus_dma.sv
// bus_dma: single-channel byte-copy DMA with a 6-byte register window and a request/grant master port.
// Defining BUS_DMA_FILL_EN builds fill mode (CTRL.MODE=1 writes SRC_LO repeatedly to the destination).
module bus_dma #(
   parameter logic [7:0] DMA_ADDRESS = 8'h90
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic [7:0]  address,
   input  logic        w_en,
   input  logic        r_en,
   output logic [7:0]  dout,
   output logic [15:0] m_address,
   output logic [7:0]  m_dout,
   input  logic [7:0]  m_din,
   output logic        m_w_en,
   output logic        m_r_en,
   output logic        m_req,
   input  logic        m_grant,
   output logic        done_flag,
   input  logic        done_flag_clr
);
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
   state_t state;

   logic [AW-1:0] src_r, dst_r, src_w, dst_w;
   logic [DW-1:0] len_r, cnt_w, data_q, wr_data, offset;
   logic          mode_r, fill_w, abort_pend;
   logic          busy, wr_ctrl, start, abort, mode_din, last;

   assign offset  = address - DMA_ADDRESS;
   assign busy    = (state != IDLE);
   assign wr_ctrl = w_en && (offset == 8'd5);
   assign start   = wr_ctrl && din[0] && !busy;
   assign abort   = wr_ctrl && din[4] && busy;
   // Count is loaded straight from LEN, so LEN=0 wraps through 255 and yields 256 bytes
   assign last    = (cnt_w == 8'd1);

`ifdef BUS_DMA_FILL_EN
   assign mode_din = din[3];
   assign wr_data  = fill_w ? src_w[7:0] : data_q;
`else
   assign mode_din = 1'b0;
   assign wr_data  = data_q;
`endif

   // Strobes follow grant within the cycle; an abort write suppresses the strobe it coincides with
   assign m_req     = (state == RD) || (state == CAP) || (state == WR);
   assign m_r_en    = (state == RD) && m_grant && !abort;
   assign m_w_en    = (state == WR) && m_grant && !abort;
   assign m_address = m_r_en ? src_w : (m_w_en ? dst_w : 16'h0000);
   assign m_dout    = m_w_en ? wr_data : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src_r      <= '0;
         dst_r      <= '0;
         len_r      <= '0;
         mode_r     <= 1'b0;
         src_w      <= '0;
         dst_w      <= '0;
         cnt_w      <= '0;
         data_q     <= '0;
         fill_w     <= 1'b0;
         abort_pend <= 1'b0;
         done_flag  <= 1'b0;
         dout       <= 8'h00;
      end else begin
         // Configuration is frozen while a transfer is in flight
         if (w_en && !busy) begin
            case (offset)
               8'd0:    src_r[7:0]  <= din;
               8'd1:    src_r[15:8] <= din;
               8'd2:    dst_r[7:0]  <= din;
               8'd3:    dst_r[15:8] <= din;
               8'd4:    len_r       <= din;
               8'd5:    mode_r      <= mode_din;
               default: ;
            endcase
         end

         if (r_en) begin
            case (offset)
               8'd0:    dout <= src_r[7:0];
               8'd1:    dout <= src_r[15:8];
               8'd2:    dout <= dst_r[7:0];
               8'd3:    dout <= dst_r[15:8];
               8'd4:    dout <= len_r;
               8'd5:    dout <= {3'b000, 1'b0, mode_r, done_flag, busy, 1'b0};
               default: dout <= 8'h00;
            endcase
         end else begin
            dout <= 8'h00;
         end

         if (done_flag_clr)
            done_flag <= 1'b0;
         else if (state == DONE && !abort)
            done_flag <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  src_w      <= src_r;
                  dst_w      <= dst_r;
                  cnt_w      <= len_r;
                  fill_w     <= mode_din;
                  abort_pend <= 1'b0;
                  state      <= mode_din ? WR : RD;
               end
            end
            RD: begin
               if (abort)
                  state <= IDLE;
               else if (m_grant)
                  state <= CAP;
            end
            CAP: begin
               // Read data is already on the bus, so an abort here still completes this byte
               data_q <= m_din;
               state  <= WR;
               if (abort)
                  abort_pend <= 1'b1;
            end
            WR: begin
               if (abort) begin
                  state <= IDLE;
               end else if (m_grant) begin
                  dst_w <= dst_w + AW'(1);
                  cnt_w <= cnt_w - DW'(1);
                  if (!fill_w)
                     src_w <= src_w + AW'(1);
                  if (abort_pend)
                     state <= IDLE;
                  else if (last)
                     state <= DONE;
                  else if (fill_w)
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: randomized self-checking bench for bus_dma; a 64 KiB byte array plays the master-bus slave
// and expected copies are computed directly as mem[src+i] -> dst+i with 16-bit wrap.
`timescale 1ns/1ps
module tb_bus_dma;
   localparam logic [7:0] BASE = 8'h90;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din, address, dout;
   logic        w_en, r_en;
   logic [15:0] m_address;
   logic [7:0]  m_dout;
   logic [7:0]  m_din = 8'h00;
   logic        m_w_en, m_r_en, m_req;
   logic        m_grant = 1'b0;
   logic        done_flag, done_flag_clr;

   bus_dma #(.DMA_ADDRESS(BASE)) dut (
      .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en), .dout(dout),
      .m_address(m_address), .m_dout(m_dout), .m_din(m_din), .m_w_en(m_w_en), .m_r_en(m_r_en),
      .m_req(m_req), .m_grant(m_grant), .done_flag(done_flag), .done_flag_clr(done_flag_clr)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [0:65535];
   logic [15:0] rq[$];
   logic [15:0] wa[$];
   logic [7:0]  wd[$];
   int          wc[$];
   int          cyc = 0, req_start = -1, viol = 0, gph = 0, grant_mode = 0;
   int          n_checks = 0, n_pass = 0;

   // Slave memory: read data appears the cycle after the read strobe
   always @(posedge clk) if (m_r_en) m_din <= mem[m_address];

   // Grant pattern: 0 always granted, 1 toggles every two cycles, 2 random
   initial begin
      forever begin
         @(posedge clk);
         #1;
         gph++;
         case (grant_mode)
            0:       m_grant = 1'b1;
            1:       m_grant = ((gph >> 1) & 1) != 0;
            2:       m_grant = ($urandom_range(0, 1) != 0);
            default: m_grant = 1'b0;
         endcase
      end
   end

   // Bus monitor, sampled late in each cycle
   always begin
      @(negedge clk);
      #4;
      cyc++;
      if (m_req && req_start < 0) req_start = cyc;
      if (m_r_en) rq.push_back(m_address);
      if (m_w_en) begin
         wa.push_back(m_address);
         wd.push_back(m_dout);
         wc.push_back(cyc);
      end
      if (m_r_en && m_w_en) viol++;
      if ((m_r_en || m_w_en) && (!m_grant || !m_req)) viol++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic reg_write(input int off, input logic [7:0] val);
      address = BASE + 8'(off);
      din     = val;
      w_en    = 1'b1;
      @(negedge clk);
      w_en    = 1'b0;
   endtask

   task automatic reg_read(input int off, output logic [7:0] val);
      address = BASE + 8'(off);
      r_en    = 1'b1;
      @(negedge clk);
      r_en    = 1'b0;
      val     = dout;
   endtask

   task automatic clear_log();
      rq.delete(); wa.delete(); wd.delete(); wc.delete();
      req_start = -1;
   endtask

   task automatic program_regs(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len);
      reg_write(0, src[7:0]);
      reg_write(1, src[15:8]);
      reg_write(2, dst[7:0]);
      reg_write(3, dst[15:8]);
      reg_write(4, len);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done_flag && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(done_flag), 32'd1);
   endtask

   task automatic clear_done(input string tag);
      done_flag_clr = 1'b1;
      @(negedge clk);
      done_flag_clr = 1'b0;
      check({tag, "_clr"}, 32'(done_flag), 32'd0);
   endtask

   task automatic check_copy(input string tag, input logic [15:0] src, input logic [15:0] dst,
                             input logic [7:0] len);
      int n   = (len == 8'd0) ? 256 : int'(len);
      int bad = 0;
      check({tag, "_nwr"}, 32'(wa.size()), 32'(n));
      for (int i = 0; i < n && i < wa.size(); i++) begin
         logic [15:0] ea, sa;
         ea = dst + 16'(i);
         sa = src + 16'(i);
         if (wa[i] !== ea || wd[i] !== mem[sa]) bad++;
      end
      check({tag, "_data"}, 32'(bad), 32'd0);
   endtask

   task automatic copy_run(input string tag, input logic [15:0] src, input logic [15:0] dst,
                           input logic [7:0] len, input int gmode, input int budget);
      logic [7:0] rd;
      clear_log();
      grant_mode = gmode;
      program_regs(src, dst, len);
      reg_write(5, 8'h01);
      wait_done(tag, budget);
      check_copy(tag, src, dst, len);
      reg_read(5, rd);
      check({tag, "_ctrl"}, 32'(rd), 32'h04);
      clear_done(tag);
   endtask

   initial begin
      logic [7:0]  rd;
      logic [15:0] s, d;
      logic [7:0]  l;
      logic [15:0] exp_r [3];
      int          n, nr, nw;

      rst = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0; done_flag_clr = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      check("rst_req",  32'(m_req), 32'd0);
      check("rst_strb", 32'({m_r_en, m_w_en}), 32'd0);
      check("rst_addr", 32'(m_address), 32'h0);
      check("rst_mdout", 32'(m_dout), 32'h0);
      check("rst_done", 32'(done_flag), 32'd0);
      check("rst_dout", 32'(dout), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         reg_read(i, rd);
         check($sformatf("rst_reg%0d", i), 32'(rd), 32'h0);
      end

      // Register readback
      s = 16'($urandom); d = 16'($urandom); l = 8'($urandom);
      program_regs(s, d, l);
      reg_read(0, rd); check("rb_src_lo", 32'(rd), 32'(s[7:0]));
      reg_read(1, rd); check("rb_src_hi", 32'(rd), 32'(s[15:8]));
      reg_read(2, rd); check("rb_dst_lo", 32'(rd), 32'(d[7:0]));
      reg_read(3, rd); check("rb_dst_hi", 32'(rd), 32'(d[15:8]));
      reg_read(4, rd); check("rb_len", 32'(rd), 32'(l));
      @(negedge clk);
      check("rb_dout_idle", 32'(dout), 32'h0);
      reg_read(6, rd); check("rb_unmapped", 32'(rd), 32'h0);
      reg_write(5, 8'h08);
      reg_read(5, rd);
`ifdef BUS_DMA_FILL_EN
      check("rb_mode", 32'(rd), 32'h08);
`else
      check("rb_mode", 32'(rd), 32'h00);
`endif
      reg_write(5, 8'h00);

      // Basic 4-byte copy with write timing relative to RD entry
      copy_run("basic", 16'h0100, 16'h0200, 8'd4, 0, 200);
      for (int i = 0; i < 4; i++)
         if (wc.size() > i) check($sformatf("basic_wcyc%0d", i), 32'(wc[i] - req_start + 1), 32'(3 * (i + 1)));
      check("basic_req_off", 32'(m_req), 32'd0);

      // Source address wrap
      d = 16'($urandom);
      copy_run("wrap", 16'hFFFE, d, 8'd3, 0, 200);
      exp_r[0] = 16'hFFFE; exp_r[1] = 16'hFFFF; exp_r[2] = 16'h0000;
      check("wrap_nrd", 32'(rq.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (rq.size() > i) check($sformatf("wrap_rd%0d", i), 32'(rq[i]), 32'(exp_r[i]));

      // Grant toggling every two cycles
      copy_run("toggle", 16'($urandom), 16'($urandom), 8'd8, 1, 500);
      check("toggle_viol", 32'(viol), 32'd0);

      // Random transfers under random grant
      for (int k = 0; k < 4; k++)
         copy_run($sformatf("rand%0d", k), 16'($urandom), 16'($urandom), 8'($urandom_range(1, 40)), 2, 2000);

      // LEN=0 is 256 bytes
      copy_run("len0", 16'($urandom), 16'($urandom), 8'd0, 0, 1500);

      // Clear held through the DONE cycle wins over the set
      clear_log();
      grant_mode = 0;
      done_flag_clr = 1'b1;
      program_regs(16'($urandom), 16'($urandom), 8'd2);
      reg_write(5, 8'h01);
      n = 0;
      while (wa.size() < 2 && n < 100) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
      done_flag_clr = 1'b0;
      @(negedge clk);
      check("clrwin_nwr", 32'(wa.size()), 32'd2);
      check("clrwin_flag", 32'(done_flag), 32'd0);
      reg_read(5, rd); check("clrwin_ctrl", 32'(rd), 32'h00);

      // Writes and START while busy are ignored
      clear_log();
      s = 16'($urandom); d = 16'($urandom);
      program_regs(s, d, 8'd6);
      reg_write(5, 8'h01);
      reg_write(0, ~s[7:0]);
      reg_write(4, 8'd50);
      reg_write(5, 8'h01);
      wait_done("busy", 200);
      repeat (10) @(negedge clk);
      check_copy("busy", s, d, 8'd6);
      reg_read(0, rd); check("busy_src_kept", 32'(rd), 32'(s[7:0]));
      reg_read(4, rd); check("busy_len_kept", 32'(rd), 32'd6);
      clear_done("busy");

      // ABORT while in RD before the third byte of ten
      clear_log();
      program_regs(16'($urandom), 16'($urandom), 8'd10);
      reg_write(5, 8'h01);
      n = 0;
      while (wa.size() < 2 && n < 100) begin @(negedge clk); n++; end
      reg_write(5, 8'h10);
      nr = rq.size(); nw = wa.size();
      repeat (10) @(negedge clk);
      check("abort_nwr", 32'(wa.size()), 32'd2);
      check("abort_no_rd", 32'(rq.size()), 32'(nr));
      check("abort_no_wr", 32'(wa.size()), 32'(nw));
      check("abort_flag", 32'(done_flag), 32'd0);
      reg_read(5, rd); check("abort_ctrl", 32'(rd), 32'h00);

      // Reset during a WR cycle
      clear_log();
      s = {8'($urandom), 8'h5A};
      program_regs(s, 16'($urandom), 8'd10);
      reg_write(5, 8'h01);
      n = 0;
      while (wa.size() < 3 && n < 100) begin @(negedge clk); n++; end
      n = 0;
      while (!m_w_en && n < 20) begin @(negedge clk); n++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nr = rq.size(); nw = wa.size();
      repeat (10) @(negedge clk);
      check("rstx_no_rd", 32'(rq.size()), 32'(nr));
      check("rstx_no_wr", 32'(wa.size()), 32'(nw));
      check("rstx_flag", 32'(done_flag), 32'd0);
      reg_read(5, rd); check("rstx_ctrl", 32'(rd), 32'h00);
      reg_read(0, rd); check("rstx_src", 32'(rd), 32'h00);

`ifdef BUS_DMA_FILL_EN
      // Fill mode: constant SRC_LO on consecutive cycles, no reads
      clear_log();
      grant_mode = 0;
      program_regs(16'h00A5, 16'h0300, 8'd5);
      reg_write(5, 8'h09);
      wait_done("fill", 100);
      check("fill_nwr", 32'(wa.size()), 32'd5);
      check("fill_nrd", 32'(rq.size()), 32'd0);
      for (int i = 0; i < 5; i++)
         if (wa.size() > i) begin
            check($sformatf("fill_addr%0d", i), 32'(wa[i]), 32'(16'h0300 + 16'(i)));
            check($sformatf("fill_data%0d", i), 32'(wd[i]), 32'hA5);
            check($sformatf("fill_cyc%0d", i), 32'(wc[i] - wc[0]), 32'(i));
         end
      reg_read(5, rd); check("fill_ctrl", 32'(rd), 32'h0C);
      clear_done("fill");
`endif

      check("viol_total", 32'(viol), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
